// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared state encoding and default parameters for the memory matrix engine
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_WAIT = 3'd1,
    S_SHOW       = 3'd2,
    S_PLAY       = 3'd3,
    S_WIN        = 3'd4,
    S_LOSE       = 3'd5,
    S_END_WAIT   = 3'd6
  } mm_state_t;

  localparam int DEF_TILES       = 8;
  localparam int DEF_SHOW_CYCLES = 50_000_000;
  localparam int DEF_FLASH_HALF  = 12_500_000;
  localparam int DEF_MISS_W      = 4;

  function automatic logic is_flash_state(input mm_state_t s);
    return s inside {S_IDLE, S_WIN, S_LOSE};
  endfunction

endpackage

// File: rtl/mm_tick_counter.sv
// rtl/mm_tick_counter.sv - cycle counter that flags its last count and wraps to zero
module mm_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] last_count,
  output logic         done
);

  logic [W-1:0] count;

  assign done = (count == last_count);

  // Counting up from zero keeps the reset and clear values identical, so the
  // first period after either is full length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= done ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/memory_matrix_engine.sv
// rtl/memory_matrix_engine.sv - memory matrix game controller: show, guess, score, win/lose display
module memory_matrix_engine
  import mm_pkg::*;
#(
  parameter  int TILES       = DEF_TILES,
  parameter  int SHOW_CYCLES = DEF_SHOW_CYCLES,
  parameter  int FLASH_HALF  = DEF_FLASH_HALF,
  parameter  int MISS_W      = DEF_MISS_W,
  localparam int IDX_W       = $clog2(TILES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TILES-1:0]  solution,
  input  logic [MISS_W-1:0] max_misses,
  input  logic              guess_valid,
  input  logic [IDX_W-1:0]  guess_idx,
  output logic [TILES-1:0]  board_led,
  output logic              flash_led,
  output logic [MISS_W-1:0] misses_left,
  output logic              guess_correct,
  output logic              guess_wrong,
  output logic              game_won,
  output logic              game_lost
);

  localparam int SHOW_W  = $clog2(SHOW_CYCLES + 1);
  localparam int FLASH_W = $clog2(FLASH_HALF + 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);

  mm_state_t         state_q, state_d;
  logic [TILES-1:0]  sol_q, found_q, found_d, guess_mask;
  logic [MISS_W-1:0] misses_q;
  logic              phase_q, won_q, correct_q, wrong_q;
  logic              idx_ok, guess_act, in_sol, in_found, new_correct, miss;
  logic              launch, show_done, flash_done, flash_enter, flash_active;

  // Non power-of-two boards can receive indices past the last tile.
  if (TILES == (1 << IDX_W)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = ({1'b0, guess_idx} < (IDX_W + 1)'(TILES));
  end

  assign guess_mask   = TILES'(1) << guess_idx;
  assign launch       = (state_q == S_START_WAIT) && !start;
  assign flash_active = is_flash_state(state_q);
  assign flash_enter  = is_flash_state(state_d) && (state_d != state_q);

  always_comb begin
    guess_act   = (state_q == S_PLAY) && guess_valid && idx_ok;
    in_sol      = |(sol_q & guess_mask);
    in_found    = |(found_q & guess_mask);
    new_correct = guess_act && in_sol && !in_found;
    miss        = guess_act && !in_sol;
    found_d     = new_correct ? (found_q | guess_mask) : found_q;
  end

  mm_tick_counter #(.W(SHOW_W)) u_show_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .enable     (state_q == S_SHOW),
    .last_count (SHOW_LAST),
    .done       (show_done)
  );

  mm_tick_counter #(.W(FLASH_W)) u_flash_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (flash_enter),
    .enable     (flash_active),
    .last_count (FLASH_LAST),
    .done       (flash_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (start) state_d = S_START_WAIT;
      S_START_WAIT:   if (!start) state_d = S_SHOW;
      S_SHOW:         if (show_done) state_d = S_PLAY;
      S_PLAY: begin
        if (miss && (misses_q <= MISS_W'(1))) state_d = S_LOSE;
        else if (found_d == sol_q)            state_d = S_WIN;
      end
      S_WIN, S_LOSE:  if (start) state_d = S_END_WAIT;
      S_END_WAIT:     if (!start) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sol_q     <= '0;
      found_q   <= '0;
      misses_q  <= '0;
      phase_q   <= 1'b0;
      won_q     <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      correct_q <= new_correct;
      wrong_q   <= miss;
      if (launch) begin
        sol_q    <= solution;
        found_q  <= '0;
        misses_q <= max_misses;
      end else begin
        found_q <= found_d;
        if (miss && (misses_q != '0)) misses_q <= misses_q - 1'b1;
      end
      if (flash_enter)                    phase_q <= 1'b0;
      else if (flash_active && flash_done) phase_q <= ~phase_q;
      if (state_q == S_PLAY) won_q <= (state_d == S_WIN);
    end
  end

  always_comb begin
    board_led = '0;
    flash_led = 1'b0;
    game_won  = 1'b0;
    game_lost = 1'b0;
    case (state_q)
      S_IDLE: flash_led = phase_q;
      S_SHOW: board_led = sol_q;
      S_PLAY: board_led = found_q;
      S_WIN: begin
        board_led = sol_q;
        flash_led = phase_q;
        game_won  = 1'b1;
      end
      S_LOSE: begin
        board_led = found_q | (sol_q & ~found_q & {TILES{phase_q}});
        flash_led = phase_q;
        game_lost = 1'b1;
      end
      S_END_WAIT: begin
        game_won  = won_q;
        game_lost = !won_q;
      end
      default: ;
    endcase
  end

  assign misses_left   = misses_q;
  assign guess_correct = correct_q;
  assign guess_wrong   = wrong_q;

endmodule
